// File: rtl/inst_fetcher.sv
// inst_fetcher: fetches instruction words from memory into a 4-entry queue with static next-pc prediction
module inst_fetcher (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        is_any_full,
   input  logic        reset_from_rob_bus,
   input  logic [31:0] pc_from_rob_bus,
   output logic        valid_to_mem,
   output logic [31:0] addr_to_mem,
   input  logic        ready_from_mem,
   input  logic [31:0] inst_from_mem,
   output logic        ready_to_issuer,
   output logic [31:0] pc_to_issuer,
   output logic [31:0] next_pc_to_issuer,
   output logic [31:0] inst_to_issuer
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]  state;
   logic [31:0] fetch_pc;
   logic [31:0] q_pc [4];
   logic [31:0] q_npc [4];
   logic [31:0] q_inst [4];
   logic [1:0]  head, tail;
   logic [2:0]  count;
   logic        flush, deq, enq, issue;
   logic [31:0] j_imm, b_imm, pred;
   assign flush = reset_from_rob_bus;
   assign ready_to_issuer   = count != 3'd0;
   assign pc_to_issuer      = q_pc[head];
   assign next_pc_to_issuer = q_npc[head];
   assign inst_to_issuer    = q_inst[head];
   assign deq   = rdy && ready_to_issuer && !is_any_full && !flush;
   assign enq   = rdy && state == BUSY && ready_from_mem && !flush;
   assign issue = rdy && state == IDLE && !flush && (count != 3'd4 || deq);
   // static prediction: JAL and backward branches taken, everything else falls through
   always_comb begin
      j_imm = {{12{inst_from_mem[31]}}, inst_from_mem[19:12], inst_from_mem[20], inst_from_mem[30:21], 1'b0};
      b_imm = {{20{inst_from_mem[31]}}, inst_from_mem[7], inst_from_mem[30:25], inst_from_mem[11:8], 1'b0};
      pred  = inst_from_mem[6:0] == 7'b1101111                     ? fetch_pc + j_imm :
              inst_from_mem[6:0] == 7'b1100011 && inst_from_mem[31] ? fetch_pc + b_imm :
                                                                      fetch_pc + 32'd4;
   end
   // queue storage written at the tail on an accepted memory response
   always_ff @(posedge clk) begin
      if (enq) begin
         q_pc[tail]   <= fetch_pc;
         q_npc[tail]  <= pred;
         q_inst[tail] <= inst_from_mem;
      end
   end
   // head/tail pointers and occupancy; a flush empties the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= 2'd0;
         tail  <= 2'd0;
         count <= 3'd0;
      end else if (rdy) begin
         if (flush) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 3'd0;
         end else begin
            if (enq) tail <= tail + 2'd1;
            if (deq) head <= head + 2'd1;
            count <= count + 3'(enq) - 3'(deq);
         end
      end
   end
   // fetch FSM; DRAIN swallows the response of a request cancelled by a flush
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         fetch_pc     <= 32'd0;
         valid_to_mem <= 1'b0;
         addr_to_mem  <= 32'd0;
      end else if (rdy) begin
         if (flush) fetch_pc <= pc_from_rob_bus;
         else if (enq) fetch_pc <= pred;
         case (state)
            IDLE: begin
               if (issue) begin
                  valid_to_mem <= 1'b1;
                  addr_to_mem  <= fetch_pc;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               if (flush || ready_from_mem) valid_to_mem <= 1'b0;
               if (ready_from_mem) state <= IDLE;
               else if (flush) state <= DRAIN;
            end
            DRAIN: begin
               if (ready_from_mem) state <= IDLE;
            end
            default: begin
               state        <= IDLE;
               valid_to_mem <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed bench with a latency-programmable memory model and an issue-order scoreboard
module tb_inst_fetcher;
   logic        clk = 1'b0;
   logic        rst, rdy, is_any_full, reset_from_rob_bus;
   logic [31:0] pc_from_rob_bus;
   logic        valid_to_mem;
   logic [31:0] addr_to_mem;
   logic        ready_from_mem = 1'b0;
   logic [31:0] inst_from_mem = 32'd0;
   logic        ready_to_issuer;
   logic [31:0] pc_to_issuer, next_pc_to_issuer, inst_to_issuer;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] inst;
   } ent_t;
   ent_t exp_q[$];
   int passed = 0;
   int total = 0;
   int lat = 2;
   logic mem_en = 1'b1;
   int kick_req = 0;
   int kick_ack = 0;
   int mcnt = -1;
   logic [31:0] maddr = 32'd0;
   int hi_cnt;

   inst_fetcher dut (
      .clk(clk), .rst(rst), .rdy(rdy), .is_any_full(is_any_full),
      .reset_from_rob_bus(reset_from_rob_bus), .pc_from_rob_bus(pc_from_rob_bus),
      .valid_to_mem(valid_to_mem), .addr_to_mem(addr_to_mem),
      .ready_from_mem(ready_from_mem), .inst_from_mem(inst_from_mem),
      .ready_to_issuer(ready_to_issuer), .pc_to_issuer(pc_to_issuer),
      .next_pc_to_issuer(next_pc_to_issuer), .inst_to_issuer(inst_to_issuer)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a == 32'h10 ? 32'hFF5FF06F : 32'h0000_0013;
   endfunction

   // memory: answers each request lat cycles after it is first seen; a kick answers immediately
   always @(negedge clk) begin
      #1;
      ready_from_mem = 1'b0;
      if (kick_req != kick_ack) begin
         kick_ack = kick_req;
         ready_from_mem = 1'b1;
         inst_from_mem = word(addr_to_mem);
         mcnt = -1;
      end else if (rst) mcnt = -1;
      else if (rdy) begin
         if (mcnt < 0) begin
            if (mem_en && valid_to_mem) begin
               mcnt = lat;
               maddr = addr_to_mem;
            end
         end else mcnt = mcnt - 1;
         if (mcnt == 0) begin
            ready_from_mem = 1'b1;
            inst_from_mem = word(maddr);
            mcnt = -1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] inst);
      ent_t e;
      e.pc = pc;
      e.npc = npc;
      e.inst = inst;
      exp_q.push_back(e);
   endtask

   // one clock: just before the edge, score any dequeue the DUT is about to perform
   task automatic cyc();
      ent_t e;
      #4;
      if (!rst && rdy && ready_to_issuer && !is_any_full && !reset_from_rob_bus && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("deq_pc", pc_to_issuer, e.pc);
         chk("deq_next_pc", next_pc_to_issuer, e.npc);
         chk("deq_inst", inst_to_issuer, e.inst);
      end
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) cyc();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      is_any_full = 1'b0;
      reset_from_rob_bus = 1'b0;
      pc_from_rob_bus = 32'd0;
      @(negedge clk);
      repeat (2) cyc();
      chk("rst_valid", 32'(valid_to_mem), 32'd0);
      chk("rst_addr", addr_to_mem, 32'd0);
      chk("rst_ready", 32'(ready_to_issuer), 32'd0);
      // sequential addi stream, then a JAL at 0x10 jumping back to 0x4
      for (int a = 0; a < 16; a += 4) push(a, a + 4, 32'h13);
      push(32'h10, 32'h4, 32'hFF5FF06F);
      push(32'h4, 32'h8, 32'h13);
      push(32'h8, 32'hC, 32'h13);
      rst = 1'b0;
      cyc();
      chk("first_req_valid", 32'(valid_to_mem), 32'd1);
      chk("first_req_addr", addr_to_mem, 32'd0);
      drain("stream_done");
      // full downstream: queue fills to 4 and fetching stops
      is_any_full = 1'b1;
      lat = 0;
      reset_from_rob_bus = 1'b1;
      pc_from_rob_bus = 32'h40;
      exp_q.delete();
      cyc();
      reset_from_rob_bus = 1'b0;
      repeat (30) cyc();
      chk("full_ready", 32'(ready_to_issuer), 32'd1);
      chk("full_head_pc", pc_to_issuer, 32'h40);
      chk("full_head_npc", next_pc_to_issuer, 32'h44);
      hi_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (valid_to_mem) hi_cnt++;
      end
      chk("full_no_req", 32'(hi_cnt), 32'd0);
      for (int a = 32'h40; a < 32'h58; a += 4) push(a, a + 4, 32'h13);
      is_any_full = 1'b0;
      repeat (4) cyc();
      chk("one_deq_per_cycle", 32'(exp_q.size()), 32'd2);
      drain("refill_done");
      // flush while BUSY at 0x20 with the response still three cycles out
      is_any_full = 1'b1;
      reset_from_rob_bus = 1'b1;
      pc_from_rob_bus = 32'h20;
      cyc();
      reset_from_rob_bus = 1'b0;
      mem_en = 1'b0;
      lat = 3;
      repeat (3) cyc();
      chk("busy20_valid", 32'(valid_to_mem), 32'd1);
      chk("busy20_addr", addr_to_mem, 32'h20);
      chk("busy20_empty", 32'(ready_to_issuer), 32'd0);
      mem_en = 1'b1;
      cyc();
      reset_from_rob_bus = 1'b1;
      pc_from_rob_bus = 32'h100;
      cyc();
      reset_from_rob_bus = 1'b0;
      chk("drain_valid_low", 32'(valid_to_mem), 32'd0);
      chk("drain_empty", 32'(ready_to_issuer), 32'd0);
      repeat (2) cyc();
      chk("no_early_req", 32'(valid_to_mem), 32'd0);
      chk("discarded_count0", 32'(ready_to_issuer), 32'd0);
      cyc();
      chk("redirect_valid", 32'(valid_to_mem), 32'd1);
      chk("redirect_addr", addr_to_mem, 32'h100);
      // flush coinciding with a response and a pending dequeue
      mem_en = 1'b0;
      kick_req++;
      cyc();
      chk("kick_ready", 32'(ready_to_issuer), 32'd1);
      chk("kick_pc", pc_to_issuer, 32'h100);
      chk("kick_npc", next_pc_to_issuer, 32'h104);
      chk("kick_inst", inst_to_issuer, 32'h13);
      cyc();
      chk("req104_addr", addr_to_mem, 32'h104);
      is_any_full = 1'b0;
      kick_req++;
      reset_from_rob_bus = 1'b1;
      pc_from_rob_bus = 32'h300;
      cyc();
      reset_from_rob_bus = 1'b0;
      is_any_full = 1'b1;
      chk("coflush_count0", 32'(ready_to_issuer), 32'd0);
      chk("coflush_idle", 32'(valid_to_mem), 32'd0);
      cyc();
      chk("coflush_valid", 32'(valid_to_mem), 32'd1);
      chk("coflush_addr", addr_to_mem, 32'h300);
      // rdy low mid-BUSY freezes everything, including a flush attempt
      lat = 2;
      mem_en = 1'b1;
      cyc();
      rdy = 1'b0;
      reset_from_rob_bus = 1'b1;
      pc_from_rob_bus = 32'h999;
      hi_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (!valid_to_mem || addr_to_mem != 32'h300 || ready_to_issuer) hi_cnt++;
      end
      chk("freeze_stable", 32'(hi_cnt), 32'd0);
      rdy = 1'b1;
      reset_from_rob_bus = 1'b0;
      push(32'h300, 32'h304, 32'h13);
      is_any_full = 1'b0;
      drain("resume_done");
      // reset wins over a coincident memory response
      is_any_full = 1'b1;
      rst = 1'b1;
      kick_req++;
      cyc();
      chk("rst2_valid", 32'(valid_to_mem), 32'd0);
      chk("rst2_addr", addr_to_mem, 32'd0);
      chk("rst2_ready", 32'(ready_to_issuer), 32'd0);
      rst = 1'b0;
      cyc();
      chk("rst2_req_valid", 32'(valid_to_mem), 32'd1);
      chk("rst2_req_addr", addr_to_mem, 32'd0);
      chk("rst2_dropped", 32'(ready_to_issuer), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
